// File: rtl/me_control.sv
// Sequencer for the 16-PE full-search motion estimator: walks 256 candidate vectors
// (x in parallel across PEs, y in time) and decodes PE strobes and memory addresses.
module me_control #(
   parameter int NPE    = 16,
   parameter int BLKLOG = 4,
   parameter int CW     = 13
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             compstart,
   output logic [7:0]       addressR,
   output logic [9:0]       addressS1,
   output logic [9:0]       addressS2,
   output logic [NPE-1:0]   en,
   output logic [NPE-1:0]   newdist,
   output logic [NPE-1:0]   peready,
   output logic [3:0]       vectorx,
   output logic [3:0]       vectory
);

   localparam int PB = 2 * BLKLOG;   // pixel index bits within one block pass
   localparam int NB = 3 * BLKLOG;   // pixel + y-offset bits for a whole search
   localparam logic [CW-1:0] C_LAST = CW'((1 << NB) + NPE - 1);
   localparam logic [3:0]    HALF   = 4'd8;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_nx;
   logic [CW-1:0]   r_c;
   logic [CW-1:0]   w_c_nx;
   logic            w_run;
   logic signed [CW:0] w_k;
   logic signed [CW:0] w_km1;
   logic [BLKLOG:0] w_row;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_c     <= '0;
      end else begin
         r_state <= w_state_nx;
         r_c     <= w_c_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_c_nx     = '0;
      unique case (r_state)
         S_IDLE:  if (start) w_state_nx = S_RUN;
         S_RUN: begin
            if (r_c == C_LAST) w_state_nx = S_DONE;
            else               w_c_nx     = r_c + CW'(1);
         end
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // PE i lags the sequence by i cycles, so its local count is k = c - i.
   always_comb begin
      w_run     = (r_state == S_RUN);
      busy      = (r_state != S_IDLE);
      compstart = (r_state != S_IDLE);
      done      = (r_state == S_DONE);
      en        = '0;
      newdist   = '0;
      peready   = '0;
      vectorx   = '0;
      vectory   = '0;
      addressR  = '0;
      addressS1 = '0;
      addressS2 = '0;
      w_k       = '0;
      w_km1     = '0;
      w_row     = '0;
      if (w_run) begin
         for (int i = 0; i < NPE; i++) begin
            w_k        = $signed({1'b0, r_c}) - $signed((CW+1)'(i));
            w_km1      = w_k - $signed((CW+1)'(1));
            en[i]      = !w_k[CW] && (w_k[CW-1:NB] == '0);
            newdist[i] = en[i] && (w_k[PB-1:0] == '0);
            if (!w_km1[CW] && (w_km1[CW-1:NB] == '0) && (w_km1[PB-1:0] == '1)) begin
               peready[i] = 1'b1;
               vectorx    = 4'(i) - HALF;
               vectory    = w_km1[NB-1:PB] - HALF;
            end
         end
         // Search window is 32 wide: bit 4 selects the left or right 16-column half.
         if (r_c[CW-1:NB] == '0) begin
            w_row     = {1'b0, r_c[NB-1:PB]} + {1'b0, r_c[PB-1:BLKLOG]};
            addressR  = r_c[PB-1:0];
            addressS1 = {w_row, 1'b0, r_c[BLKLOG-1:0]};
            addressS2 = {w_row, 1'b1, r_c[BLKLOG-1:0]};
         end
      end
   end

endmodule

// File: tb/tb_me_control.sv
// Bench for me_control: table of decoded outputs at chosen cycles, plus a PE-array and
// comparator model whose best vector is scored against a directly computed golden SAD minimum.
module tb_me_control;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        busy, done, compstart;
   logic [7:0]  addressR;
   logic [9:0]  addressS1, addressS2;
   logic [15:0] en, newdist, peready;
   logic [3:0]  vectorx, vectory;
   logic [86:0] obs;

   always #5 clock = ~clock;

   me_control dut (
      .clock(clock), .reset(reset), .start(start),
      .busy(busy), .done(done), .compstart(compstart),
      .addressR(addressR), .addressS1(addressS1), .addressS2(addressS2),
      .en(en), .newdist(newdist), .peready(peready),
      .vectorx(vectorx), .vectory(vectory)
   );

   assign obs = {busy, done, compstart, addressR, addressS1, addressS2,
                 en, newdist, peready, vectorx, vectory};

   int nvec = 0;
   int nmis = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: actual %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [86:0] mk(input logic b, input logic d, input logic cs,
                                      input logic [7:0] ar, input logic [9:0] s1,
                                      input logic [9:0] s2, input logic [15:0] e,
                                      input logic [15:0] nd, input logic [15:0] pr,
                                      input logic [3:0] vx, input logic [3:0] vy);
      return {b, d, cs, ar, s1, s2, e, nd, pr, vx, vy};
   endfunction

   typedef struct {
      int          c;
      string       name;
      logic [86:0] o;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input int c, input string nm, input logic [86:0] o);
      vec_t v;
      v.c = c; v.name = nm; v.o = o;
      tbl.push_back(v);
   endtask

   // Pixel memories shared by the golden model and the PE-array model.
   logic [7:0] refm [256];
   logic [7:0] win  [1024];

   task automatic fill(input int pdx, input int pdy);
      for (int i = 0; i < 256; i++)  refm[i] = 8'($urandom);
      for (int i = 0; i < 1024; i++) win[i]  = 8'($urandom);
      if (pdx >= 0)
         for (int r = 0; r < 256; r++) win[(pdy + r / 16) * 32 + r % 16 + pdx] = refm[r];
   endtask

   function automatic logic [7:0] golden();
      int best, bdx, bdy, s, d;
      best = -1; bdx = 0; bdy = 0;
      for (int dy = 0; dy < 16; dy++)
         for (int dx = 0; dx < 16; dx++) begin
            s = 0;
            for (int r = 0; r < 256; r++) begin
               d = int'(refm[r]) - int'(win[(dy + r / 16) * 32 + r % 16 + dx]);
               s += (d < 0) ? -d : d;
            end
            if (best < 0 || s < best) begin best = s; bdx = dx; bdy = dy; end
         end
      return {4'(bdx - 8), 4'(bdy - 8)};
   endfunction

   logic [7:0] sbq[$];

   int   acc [16];
   int   hR  [4112];
   int   hS  [4112];
   int   mcyc = 0;
   int   bestv = 0;
   logic bvalid = 1'b0;
   logic [3:0] bx = '0, by = '0;
   int   prcount = 0, pr_multi = 0, done_count = 0;
   logic pr_seq_err = 1'b0, en_err = 1'b0;

   always @(negedge clock) begin : mon
      int t, d, j;
      if (!compstart) bvalid = 1'b0;
      if ($countones(peready) > 1) pr_multi++;
      for (int i = 0; i < 16; i++)
         if (peready[i]) begin
            j = prcount;
            if (j >= 256 || i != j % 16 || vectorx != 4'(j % 16 - 8) || vectory != 4'(j / 16 - 8))
               pr_seq_err = 1'b1;
            prcount++;
            if (!bvalid || acc[i] < bestv) begin
               bestv = acc[i]; bx = vectorx; by = vectory; bvalid = 1'b1;
            end
         end
      if (busy && !done) begin
         if (mcyc < 4112) begin
            hR[mcyc] = int'(addressR);
            hS[mcyc] = int'(addressS1);
            for (int i = 0; i < 16; i++)
               if (en[i]) begin
                  t = mcyc - i;
                  if (t < 0) en_err = 1'b1;
                  else begin
                     d = int'(refm[hR[t]]) - int'(win[hS[t] + i]);
                     if (d < 0) d = -d;
                     acc[i] = newdist[i] ? d : acc[i] + d;
                  end
               end
         end else en_err = 1'b1;
         mcyc++;
      end else mcyc = 0;
      if (done) begin
         done_count++;
         if (sbq.size() == 0) chk("unexpected_done", 128'(1), 128'(0));
         else chk("best_vector", 128'({bx, by}), 128'(sbq.pop_front()));
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 5000) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   int ti, cyc;

   initial begin
      reset = 1'b1;
      start = 1'b0;
      add(0,    "c0",    mk(1,0,1, 8'h00, 10'd0,   10'd16,  16'h0001, 16'h0001, 16'h0000, 4'd0, 4'd0));
      add(1,    "c1",    mk(1,0,1, 8'h01, 10'd1,   10'd17,  16'h0003, 16'h0002, 16'h0000, 4'd0, 4'd0));
      add(15,   "c15",   mk(1,0,1, 8'h0F, 10'd15,  10'd31,  16'hFFFF, 16'h8000, 16'h0000, 4'd0, 4'd0));
      add(16,   "c16",   mk(1,0,1, 8'h10, 10'd32,  10'd48,  16'hFFFF, 16'h0000, 16'h0000, 4'd0, 4'd0));
      add(256,  "c256",  mk(1,0,1, 8'h00, 10'd32,  10'd48,  16'hFFFF, 16'h0001, 16'h0001, 4'd8, 4'd8));
      add(271,  "c271",  mk(1,0,1, 8'h0F, 10'd47,  10'd63,  16'hFFFF, 16'h8000, 16'h8000, 4'd7, 4'd8));
      add(933,  "c3A5",  mk(1,0,1, 8'hA5, 10'd421, 10'd437, 16'hFFFF, 16'h0000, 16'h0000, 4'd0, 4'd0));
      add(4095, "c4095", mk(1,0,1, 8'hFF, 10'd975, 10'd991, 16'hFFFF, 16'h0000, 16'h0000, 4'd0, 4'd0));
      add(4096, "c4096", mk(1,0,1, 8'h00, 10'd0,   10'd0,   16'hFFFE, 16'h0000, 16'h0001, 4'd8, 4'd7));
      add(4111, "c4111", mk(1,0,1, 8'h00, 10'd0,   10'd0,   16'h0000, 16'h0000, 16'h8000, 4'd7, 4'd7));
      add(4112, "done",  mk(1,1,1, 8'h00, 10'd0,   10'd0,   16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0));
      add(4113, "idle",  87'd0);

      fill(3, 12);
      repeat (3) @(negedge clock);
      chk("reset_hold", 128'(obs), 128'(0));
      reset = 1'b0;
      repeat (10) @(negedge clock);
      chk("idle_no_start", 128'(obs), 128'(0));

      // Full run with table checks at chosen counts.
      prcount = 0; pr_multi = 0; pr_seq_err = 1'b0; en_err = 1'b0; done_count = 0;
      sbq.push_back(golden());
      pulse_start();
      ti = 0;
      for (int n = 0; n <= 4113; n++) begin
         if (n > 0) @(negedge clock);
         if (ti < tbl.size() && tbl[ti].c == n) begin
            chk(tbl[ti].name, 128'(obs), 128'(tbl[ti].o));
            ti++;
         end
      end
      chk("pr_count",   128'(prcount), 128'(256));
      chk("pr_multi",   128'(pr_multi), 128'(0));
      chk("pr_order",   128'(pr_seq_err), 128'(0));
      chk("pe_timing",  128'(en_err), 128'(0));
      chk("done_count", 128'(done_count), 128'(1));

      // Start held high across a whole run, including the DONE cycle.
      fill(-1, 0);
      done_count = 0; prcount = 0;
      sbq.push_back(golden());
      start = 1'b1;
      @(negedge clock);
      wait_done(cyc);
      chk("held_latency", 128'(cyc), 128'(4112));
      @(negedge clock);
      chk("held_back_idle", 128'(obs), 128'(0));
      start = 1'b0;
      repeat (3) @(negedge clock);
      chk("held_one_search", 128'({busy, 8'(done_count)}), 128'({1'b0, 8'd1}));

      // Fresh start from IDLE begins a new run.
      prcount = 0;
      sbq.push_back(golden());
      pulse_start();
      wait_done(cyc);
      chk("fresh_latency", 128'(cyc), 128'(4112));
      chk("fresh_pr_count", 128'(prcount), 128'(256));

      // Reset mid-run at c=2000, then a clean search.
      @(negedge clock);
      fill(9, 2);
      done_count = 0; prcount = 0;
      sbq.push_back(golden());
      pulse_start();
      repeat (2000) @(negedge clock);
      chk("pre_abort_addr", 128'({busy, addressR}), 128'({1'b1, 8'hD0}));
      #2 reset = 1'b1;
      #1 chk("async_reset", 128'(obs), 128'(0));
      sbq.delete();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      sbq.push_back(golden());
      prcount = 0; pr_seq_err = 1'b0; en_err = 1'b0;
      pulse_start();
      wait_done(cyc);
      chk("post_reset_latency", 128'(cyc), 128'(4112));
      @(negedge clock);
      chk("post_reset_idle", 128'(obs), 128'(0));
      chk("post_reset_done_count", 128'(done_count), 128'(1));
      chk("post_reset_pr", 128'({pr_seq_err, en_err, 16'(prcount)}), 128'({1'b0, 1'b0, 16'd256}));
      chk("scoreboard_empty", 128'(sbq.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
